video_ula: RTL



---
 rtl/video_ula.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/video_ula.sv
`timescale 1ns/1ps
// video_ula: divides CLK into the CRTC character enable, serializes screen bytes
// through the palette with cursor overlay, and registers the resulting RGB.
module video_ula (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PROC_en,
  input  logic       nCS_VIDULA,
  input  logic       RnW,
  input  logic       A0,
  input  logic [7:0] DATABUS,
  input  logic       DISEN,
  input  logic       CURSOR,
  input  logic [7:0] VRAM_DATA,
  output logic       CRTC_en,
  output logic       RED,
  output logic       GREEN,
  output logic       BLUE
);

  typedef enum logic [2:0] {
    CUR_IDLE = 3'd0,
    CUR_S0   = 3'd1,
    CUR_S1   = 3'd2,
    CUR_S2   = 3'd3,
    CUR_S3   = 3'd4
  } cur_state_t;

  logic [3:0] r_div;
  logic [7:0] r_ctrl;
  logic [3:0] r_palette [16];
  logic [7:0] r_sr;
  logic [2:0] r_rgb;
  cur_state_t r_cur_state;
  cur_state_t w_cur_next;
  logic       w_wr;
  logic       w_crtc_en;
  logic       w_pix_en;
  logic       w_cur_on;
  logic [3:0] w_pal_idx;
  logic [3:0] w_phys;
  logic [2:0] w_col;
  logic       w_unused_ctrl1;

  // CTRL[1] is stored for software but drives nothing.
  assign w_unused_ctrl1 = r_ctrl[1];

  assign w_wr      = ~nCS_VIDULA & ~RnW & PROC_en;
  assign w_pal_idx = {r_sr[7], r_sr[5], r_sr[3], r_sr[1]};
  assign w_phys    = r_palette[w_pal_idx];
  assign w_col     = w_phys[2:0] ^ {3{w_phys[3] & r_ctrl[0]}};

  // Character clock enable at 2 MHz or 1 MHz.
  always_comb begin
    w_crtc_en = 1'b0;
    if (r_ctrl[4]) begin
      w_crtc_en = (r_div[2:0] == 3'd7);
    end else begin
      w_crtc_en = (r_div == 4'd15);
    end
  end

  // Pixel shift enable at 2/4/8/16 MHz.
  always_comb begin
    w_pix_en = 1'b0;
    case (r_ctrl[3:2])
      2'b00:   w_pix_en = (r_div[2:0] == 3'd7);
      2'b01:   w_pix_en = (r_div[1:0] == 2'd3);
      2'b10:   w_pix_en = r_div[0];
      2'b11:   w_pix_en = 1'b1;
      default: w_pix_en = 1'b0;
    endcase
  end

  // Cursor sequence: a CURSOR sample always restarts at S0.
  always_comb begin
    w_cur_next = r_cur_state;
    if (w_crtc_en) begin
      if (CURSOR) begin
        w_cur_next = CUR_S0;
      end else begin
        case (r_cur_state)
          CUR_S0:  w_cur_next = CUR_S1;
          CUR_S1:  w_cur_next = CUR_S2;
          CUR_S2:  w_cur_next = CUR_S3;
          CUR_S3:  w_cur_next = CUR_IDLE;
          default: w_cur_next = CUR_IDLE;
        endcase
      end
    end else begin
      w_cur_next = r_cur_state;
    end
  end

  // Cursor segment enables from CTRL[7:5].
  always_comb begin
    w_cur_on = 1'b0;
    case (r_cur_state)
      CUR_S0:  w_cur_on = r_ctrl[7];
      CUR_S1:  w_cur_on = r_ctrl[6];
      CUR_S2:  w_cur_on = r_ctrl[5];
      CUR_S3:  w_cur_on = r_ctrl[5];
      default: w_cur_on = 1'b0;
    endcase
  end

  // Divider, processor registers, shift register, cursor state and RGB.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_div       <= 4'd0;
      r_ctrl      <= 8'h00;
      r_sr        <= 8'h00;
      r_rgb       <= 3'b000;
      r_cur_state <= CUR_IDLE;
      for (int i = 0; i < 16; i++) begin
        r_palette[i] <= 4'h0;
      end
    end else begin
      r_div       <= r_div + 4'd1;
      r_cur_state <= w_cur_next;
      r_rgb       <= w_col ^ {3{w_cur_on}};
      if (w_crtc_en) begin
        r_sr <= DISEN ? VRAM_DATA : 8'h00;
      end else if (w_pix_en) begin
        r_sr <= {r_sr[6:0], 1'b1};
      end else begin
        r_sr <= r_sr;
      end
      if (w_wr && !A0) begin
        r_ctrl <= DATABUS;
      end else if (w_wr && A0) begin
        r_palette[DATABUS[7:4]] <= DATABUS[3:0];
      end else begin
        r_ctrl <= r_ctrl;
      end
    end
  end

  assign CRTC_en = w_crtc_en;
  assign RED     = r_rgb[2];
  assign GREEN   = r_rgb[1];
  assign BLUE    = r_rgb[0];

endmodule
